// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the single system bus.
//
// Each granted transfer runs ADDR (one cycle) then DATA (until hready).
// Ownership is released only at the end of DATA. At that point the next
// winner is picked in the same edge, so back-to-back transfers need no
// idle cycle. Every output comes straight from a flop.
//
// Optional build macro: ARB_TIMEOUT_EN
//   When defined, a stuck DATA phase is released after TIMEOUT cycles and
//   timeout_err pulses for one cycle.
//   When undefined, DATA waits for hready forever and timeout_err is 0.
//
// Handshake contract (single statement for checker binding):
//   A master owns the bus from the edge that raises its grant bit
//   (addr_phase=1) until the edge at which DATA ends (hready=1, or a forced
//   release). req is sampled only in IDLE and at the last DATA cycle.
//   hready is sampled only in DATA.
//
// The FSM state is kept in the named signal 'state' (type state_t) so that
// assertion and coverage code can bind to it directly.

module bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDW         = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDW-1:0]         master_id,
  output logic                   addr_phase,
  output logic                   data_phase,
  output logic                   timeout_err
);

  // ---------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------
  if (NUM_MASTERS < 2 || NUM_MASTERS > 4) begin : g_bad_num_masters
    $error("bus_arbiter: NUM_MASTERS must be in 2..4");
  end
  if ((1 << IDW) < NUM_MASTERS) begin : g_bad_idw
    $error("bus_arbiter: IDW too narrow to encode NUM_MASTERS");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT must be in 2..255");
  end

  // ---------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [IDW-1:0] LAST_RESET = IDW'(NUM_MASTERS - 1);

  state_t                   state;
  state_t                   state_n;

  // last winner; the search for the next winner starts one past it
  logic [IDW-1:0]           last;
  logic [IDW-1:0]           last_n;

  // next values of the registered outputs
  logic [NUM_MASTERS-1:0]   grant_n;
  logic [IDW-1:0]           master_id_n;
  logic                     addr_phase_n;
  logic                     data_phase_n;

  // arbitration result for the current req/last
  logic                     any_req;
  logic                     pick_found;
  logic [IDW-1:0]           pick_id;
  logic [NUM_MASTERS-1:0]   pick_onehot;

  // DATA ends this edge (slave completed or forced release)
  logic                     tmo_hit;
  logic                     release_bus;

  assign any_req = |req;

  // ---------------------------------------------------------------------
  // Round-robin pick.
  // Two passes give the wrap-around search without a modulo:
  //   - first, the indices strictly above 'last';
  //   - then, the indices from 0 up to and including 'last'.
  // The first set bit wins, so the previous owner has the lowest priority.
  // ---------------------------------------------------------------------
  // Winner search over req, starting just after the previous owner
  always_comb begin
    pick_found  = 1'b0;
    pick_id     = '0;
    pick_onehot = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!pick_found && req[i] && (i > int'(last))) begin
        pick_found     = 1'b1;
        pick_id        = IDW'(i);
        pick_onehot[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!pick_found && req[i] && (i <= int'(last))) begin
        pick_found     = 1'b1;
        pick_id        = IDW'(i);
        pick_onehot[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Optional DATA-phase watchdog
  // ---------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic [7:0] tmo_cnt_n;
  logic       tmo_err_q;

  // The count reaching TIMEOUT-1 with hready still low ends DATA at this edge
  assign tmo_hit     = (state == ST_DATA) && !hready &&
                       (tmo_cnt == 8'(TIMEOUT - 1));
  assign timeout_err = tmo_err_q;

  // Counter clears on the way into DATA and counts stalled DATA cycles
  always_comb begin
    tmo_cnt_n = tmo_cnt;
    if (state == ST_ADDR) begin
      tmo_cnt_n = 8'd0;
    end else if (state == ST_DATA && !hready && !tmo_hit) begin
      tmo_cnt_n = tmo_cnt + 8'd1;
    end
  end

  // Watchdog counter and one-cycle error pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt   <= 8'd0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt   <= tmo_cnt_n;
      tmo_err_q <= tmo_hit;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign release_bus = (state == ST_DATA) && (hready || tmo_hit);

  // ---------------------------------------------------------------------
  // FSM next-state and next-output logic.
  // Outputs are computed here and registered below, so nothing leaves the
  // block combinationally from req or hready.
  // ---------------------------------------------------------------------
  // Next state, next outputs and next 'last' for the arbiter FSM
  always_comb begin
    state_n      = state;
    last_n       = last;
    grant_n      = grant;
    master_id_n  = master_id;
    addr_phase_n = 1'b0;
    data_phase_n = 1'b0;

    unique case (state)
      ST_IDLE: begin
        grant_n = '0;
        if (any_req) begin
          state_n      = ST_ADDR;
          grant_n      = pick_onehot;
          master_id_n  = pick_id;
          last_n       = pick_id;
          addr_phase_n = 1'b1;
        end
      end

      // Address phase is always exactly one cycle; hready is not looked at
      ST_ADDR: begin
        state_n      = ST_DATA;
        data_phase_n = 1'b1;
      end

      ST_DATA: begin
        data_phase_n = 1'b1;
        if (release_bus) begin
          data_phase_n = 1'b0;
          if (any_req) begin
            // back-to-back hand-over, no idle cycle
            state_n      = ST_ADDR;
            grant_n      = pick_onehot;
            master_id_n  = pick_id;
            last_n       = pick_id;
            addr_phase_n = 1'b1;
          end else begin
            state_n = ST_IDLE;
            grant_n = '0;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
      end
    endcase
  end

  // State, arbitration pointer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last       <= LAST_RESET;
      grant      <= '0;
      master_id  <= '0;
      addr_phase <= 1'b0;
      data_phase <= 1'b0;
    end else begin
      state      <= state_n;
      last       <= last_n;
      grant      <= grant_n;
      master_id  <= master_id_n;
      addr_phase <= addr_phase_n;
      data_phase <= data_phase_n;
    end
  end

  // ---------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------
  // grant is idle-zero or one-hot at every edge
  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant));

  // the two phase flags are mutually exclusive
  a_phase_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(addr_phase && data_phase));

  // master_id always names an existing master
  a_id_range: assert property (@(posedge clk) disable iff (!rst_n)
    int'(master_id) < NUM_MASTERS);

  // addr_phase never lasts more than one cycle
  a_addr_single: assert property (@(posedge clk) disable iff (!rst_n)
    addr_phase |=> !addr_phase);

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that shares the single system bus between NUM_MASTERS requesters.
- Sequences each granted transfer through address and data phases and holds ownership until the slave completes the transfer (hready).
- master_id is the routing index for the master-side write/address muxes.
- data_phase tells the slave-side read path that a registered read return is valid to consume.

Parameters:
- NUM_MASTERS, 2, number of requesting masters; legal range 2..4.
- IDW, 2, width of master_id; must satisfy 2**IDW >= NUM_MASTERS.
- TIMEOUT, 16, data-phase cycles before forced release; used only with ARB_TIMEOUT_EN; legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_MASTERS  per-master bus request, level-sensitive.
- hready  input  1  transfer-complete from the selected slave; sampled only in DATA.
- grant  output  NUM_MASTERS  one-hot ownership, registered; all-zero when the bus is idle.
- master_id  output  IDW  binary index of the granted master, registered.
- addr_phase  output  1  high for exactly one cycle per transfer, in ADDR.
- data_phase  output  1  high while in DATA.
- timeout_err  output  1  one-cycle pulse on forced release; see Optional Feature.

Behaviour:
- Reset: clk and rst_n as named above; reset is asynchronous and active-low.
  - Asynchronous assertion forces state=IDLE, grant=0, master_id=0, addr_phase=0, data_phase=0, timeout_err=0, last=NUM_MASTERS-1.
  - With last=NUM_MASTERS-1, master 0 has top priority after reset.
  - Deassertion takes effect at the next clk edge.
- All outputs are registered, driven directly from state or flops; no combinational path from inputs to outputs.
- Round-robin pick: search req starting at index (last+1) mod NUM_MASTERS and wrap past NUM_MASTERS-1 to 0. The first set bit wins. last is updated to the winner at grant time.
- FSM states:
  - IDLE: grant=0. If |req at edge t, then at t+1 the state is ADDR, grant=onehot(winner), master_id=winner, addr_phase=1. Otherwise stay in IDLE.
  - ADDR: lasts exactly one cycle, then DATA (addr_phase=0, data_phase=1). hready is ignored in ADDR.
  - DATA: on hready=1, end the transfer.
    - If |req (including the current master, now lowest priority), go directly to ADDR with a new winner. This is back-to-back, with no idle cycle.
    - Otherwise go to IDLE with grant=0 and data_phase=0.
    - On hready=0, hold grant and master_id unchanged.
- Latency: req to grant is 1 cycle from IDLE. The minimum transfer is 2 cycles (ADDR + DATA with hready=1).
- A master dropping req mid-transfer has no effect; the current transfer completes.
- New or changed req during ADDR/DATA is considered only at the next arbitration point.
- Single requester holding req continuously is re-granted each transfer. This gives the pattern ADDR, DATA, ADDR, DATA...
- req bits at index >= NUM_MASTERS do not exist; master_id never exceeds NUM_MASTERS-1.
- Invariants: grant is always zero or one-hot. addr_phase and data_phase are never high together.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to DATA and increments each DATA cycle with hready=0.
  - When the count reaches TIMEOUT-1 with hready still 0, the next edge forces release exactly as if hready=1 (re-arbitrate or go to IDLE). timeout_err pulses high for that one cycle.
  - Reset clears the counter.
- Undefined: no counter is present, timeout_err is tied to 0, and DATA waits indefinitely for hready.

Test Plan:
- Reset then req=2'b01 at cycle 0 -> cycle 1: grant=01, master_id=0, addr_phase=1; cycle 2: data_phase=1; hready=1 at cycle 2 with req=0 -> cycle 3: IDLE, grant=00.
- req=2'b11 held, hready=1 every DATA cycle -> grants alternate 01,10,01,10 on successive ADDR cycles, no idle gap between transfers.
- NUM_MASTERS=3, req=3'b101 after master 2 last granted -> master 0 granted next; then master 2; master 1 never granted while its req=0.
- hready held 0 for 5 DATA cycles while req changes 01->10 -> grant stays 01 and master_id stays 0 all 5 cycles; master 1 granted only after hready=1.
- rst_n asserted mid-DATA, asynchronously between clk edges -> grant=0, data_phase=0, master_id=0 immediately, before the next edge; after release, req=10 -> master 1 granted.
- ARB_TIMEOUT_EN, TIMEOUT=4, hready stuck 0 -> forced release after 4 DATA cycles, timeout_err=1 for exactly 1 cycle, waiting master granted next; macro undefined -> grant held indefinitely, timeout_err=0.
